// File: rtl/imm_gen_pkg.sv
// Shared opcode constants and immediate-format encoding for the immediate generator.
package imm_gen_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_Z    = 3'd6
  } imm_type_e;

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational immediate extraction and format classification for one instruction word.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_type_e       imm_type
);

  logic [31:0] imm32;

  always_comb begin
    imm32    = '0;
    imm_type = IMM_NONE;
    case (instr[6:0])
      OPC_LUI, OPC_AUIPC: begin
        imm32    = {instr[31:12], 12'b0};
        imm_type = IMM_U;
      end
      OPC_JAL: begin
        imm32    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        imm_type = IMM_J;
      end
      OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
        imm32    = {{20{instr[31]}}, instr[31:20]};
        imm_type = IMM_I;
      end
      OPC_OP_IMM32: begin
        if (XLEN == 64) begin
          imm32    = {{20{instr[31]}}, instr[31:20]};
          imm_type = IMM_I;
        end
      end
      OPC_STORE: begin
        imm32    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        imm_type = IMM_S;
      end
      OPC_BRANCH: begin
        imm32    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        imm_type = IMM_B;
      end
      OPC_SYSTEM: begin
        if (instr[14]) begin
          imm32    = {27'b0, instr[19:15]};
          imm_type = IMM_Z;
        end
      end
      default: begin
        imm32    = '0;
        imm_type = IMM_NONE;
      end
    endcase
  end

  // zimm has bit 31 clear, so a uniform sign extension also zero-extends it
  assign imm = XLEN'(signed'(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: decode on input, output register plus one skid entry.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output imm_type_e        out_type,
  output logic [TAG_W-1:0] out_tag
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0]  dec_imm;
  imm_type_e        dec_type;

  logic             skid_valid;
  logic [XLEN-1:0]  skid_imm;
  imm_type_e        skid_type;
  logic [TAG_W-1:0] skid_tag;

  logic accept;
  logic out_free;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr    (in_instr),
    .imm      (dec_imm),
    .imm_type (dec_type)
  );

  // in_ready is a pure flop output: no path from out_ready
  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready;
  assign out_free = ~out_valid | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_imm    <= '0;
      out_type   <= IMM_NONE;
      out_tag    <= '0;
      skid_valid <= 1'b0;
      skid_imm   <= '0;
      skid_type  <= IMM_NONE;
      skid_tag   <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_free) begin
      if (skid_valid) begin
        // skid is older than anything on the input; in_ready is low so nothing is accepted
        out_valid  <= 1'b1;
        out_imm    <= skid_imm;
        out_type   <= skid_type;
        out_tag    <= skid_tag;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        out_imm   <= dec_imm;
        out_type  <= dec_type;
        out_tag   <= in_tag;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_imm   <= dec_imm;
      skid_type  <= dec_type;
      skid_tag   <= in_tag;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances, handshake, flush and reset.
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_imm;
  imm_type_e   out_type;
  logic [31:0] out_tag;

  logic        flush_64 = 1'b0;
  logic        in_valid_64 = 1'b0;
  logic        in_ready_64;
  logic [31:0] in_instr_64 = '0;
  logic [31:0] in_tag_64 = '0;
  logic        out_valid_64;
  logic        out_ready_64 = 1'b1;
  logic [63:0] out_imm_64;
  imm_type_e   out_type_64;
  logic [31:0] out_tag_64;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u_dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm   (out_imm),
    .out_type  (out_type),
    .out_tag   (out_tag)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) u_dut64 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush_64),
    .in_valid  (in_valid_64),
    .in_ready  (in_ready_64),
    .in_instr  (in_instr_64),
    .in_tag    (in_tag_64),
    .out_valid (out_valid_64),
    .out_ready (out_ready_64),
    .out_imm   (out_imm_64),
    .out_type  (out_type_64),
    .out_tag   (out_tag_64)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] v32_instr [7];
  logic [31:0] v32_imm   [7];
  imm_type_e   v32_type  [7];
  logic [31:0] v64_instr [3];
  logic [63:0] v64_imm   [3];
  imm_type_e   v64_type  [3];

  initial begin
    v32_instr = '{32'hFF400093, 32'hFE100EE3, 32'hFF9FF0EF, 32'h12345037,
                  32'h300FD0F3, 32'h30009073, 32'h0000001B};
    v32_imm   = '{32'hFFFFFFF4, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000,
                  32'h0000001F, 32'h00000000, 32'h00000000};
    v32_type  = '{IMM_I, IMM_B, IMM_J, IMM_U, IMM_Z, IMM_NONE, IMM_NONE};
    v64_instr = '{32'hFEDCB037, 32'h80000013, 32'hFFF0001B};
    v64_imm   = '{64'hFFFFFFFFFEDCB000, 64'hFFFFFFFFFFFFF800, 64'hFFFFFFFFFFFFFFFF};
    v64_type  = '{IMM_U, IMM_I, IMM_I};

    // reset state
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_type", 64'(out_type), 64'(IMM_NONE));
    check("rst_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_instr = 32'h12345037;
    step();
    check("rst_handshake_ignored", 64'(out_valid), 64'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    step();

    // XLEN=32 streaming at full rate, 1-cycle latency
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_instr = v32_instr[i];
      in_tag   = 32'(i + 100);
      check($sformatf("s32_in_ready_%0d", i), 64'(in_ready), 64'd1);
      step();
      check($sformatf("s32_valid_%0d", i), 64'(out_valid), 64'd1);
      check($sformatf("s32_imm_%0d", i), 64'(out_imm), 64'(v32_imm[i]));
      check($sformatf("s32_type_%0d", i), 64'(out_type), 64'(v32_type[i]));
      check($sformatf("s32_tag_%0d", i), 64'(out_tag), 64'(i + 100));
    end
    in_valid = 1'b0;
    step();
    check("s32_drained", 64'(out_valid), 64'd0);

    // XLEN=64 vectors
    for (int i = 0; i < 3; i++) begin
      in_valid_64 = 1'b1;
      in_instr_64 = v64_instr[i];
      in_tag_64   = 32'(i + 200);
      step();
      check($sformatf("s64_valid_%0d", i), 64'(out_valid_64), 64'd1);
      check($sformatf("s64_imm_%0d", i), out_imm_64, v64_imm[i]);
      check($sformatf("s64_type_%0d", i), 64'(out_type_64), 64'(v64_type[i]));
      check($sformatf("s64_tag_%0d", i), 64'(out_tag_64), 64'(i + 200));
    end
    in_valid_64 = 1'b0;
    step();
    check("s64_drained", 64'(out_valid_64), 64'd0);

    // backpressure: tags 1,2 accepted, 3 held, then drained in order
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00100093;
    in_tag    = 32'd1;
    step();
    check("bp_t1_valid", 64'(out_valid), 64'd1);
    check("bp_t1_tag", 64'(out_tag), 64'd1);
    check("bp_t1_in_ready", 64'(in_ready), 64'd1);
    in_instr = 32'h00200093;
    in_tag   = 32'd2;
    step();
    check("bp_t2_in_ready", 64'(in_ready), 64'd0);
    check("bp_t2_out_tag", 64'(out_tag), 64'd1);
    in_instr = 32'h00300093;
    in_tag   = 32'd3;
    step();
    check("bp_hold_tag", 64'(out_tag), 64'd1);
    check("bp_hold_imm", 64'(out_imm), 64'd1);
    check("bp_hold_in_ready", 64'(in_ready), 64'd0);
    step();
    check("bp_hold2_valid", 64'(out_valid), 64'd1);
    check("bp_hold2_tag", 64'(out_tag), 64'd1);
    out_ready = 1'b1;
    step();
    check("bp_d2_tag", 64'(out_tag), 64'd2);
    check("bp_d2_imm", 64'(out_imm), 64'd2);
    check("bp_d2_in_ready", 64'(in_ready), 64'd1);
    step();
    check("bp_d3_valid", 64'(out_valid), 64'd1);
    check("bp_d3_tag", 64'(out_tag), 64'd3);
    check("bp_d3_imm", 64'(out_imm), 64'd3);
    in_valid = 1'b0;
    step();
    check("bp_empty", 64'(out_valid), 64'd0);

    // flush with both entries full and a same-cycle input
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00100093;
    in_tag    = 32'd1;
    step();
    in_instr = 32'h00200093;
    in_tag   = 32'd2;
    step();
    check("fl_full_in_ready", 64'(in_ready), 64'd0);
    in_instr = 32'h00300093;
    in_tag   = 32'd3;
    flush    = 1'b1;
    step();
    check("fl_out_valid", 64'(out_valid), 64'd0);
    check("fl_in_ready", 64'(in_ready), 64'd1);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("fl_no_tag3_a", 64'(out_valid), 64'd0);
    step();
    check("fl_no_tag3_b", 64'(out_valid), 64'd0);

    // flush while skid is empty: the accepted-looking input must be discarded
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00400093;
    in_tag    = 32'd4;
    step();
    in_instr = 32'h00500093;
    in_tag   = 32'd5;
    flush    = 1'b1;
    step();
    check("fl2_out_valid", 64'(out_valid), 64'd0);
    check("fl2_in_ready", 64'(in_ready), 64'd1);
    flush    = 1'b0;
    in_valid = 1'b0;
    step();
    check("fl2_no_tag5", 64'(out_valid), 64'd0);

    // asynchronous reset mid-stream
    in_valid = 1'b1;
    in_instr = 32'hFF400093;
    in_tag   = 32'd7;
    step();
    check("ar_pre_valid", 64'(out_valid), 64'd1);
    in_tag = 32'd8;
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_out_valid", 64'(out_valid), 64'd0);
    check("ar_out_imm", 64'(out_imm), 64'd0);
    check("ar_out_tag", 64'(out_tag), 64'd0);
    check("ar_out_type", 64'(out_type), 64'(IMM_NONE));
    check("ar_in_ready", 64'(in_ready), 64'd1);
    step();
    check("ar_held_valid", 64'(out_valid), 64'd0);
    rst_n    = 1'b1;
    out_ready = 1'b1;
    in_instr = 32'h12345037;
    in_tag   = 32'd9;
    step();
    check("ar_post_valid", 64'(out_valid), 64'd1);
    check("ar_post_tag", 64'(out_tag), 64'd9);
    check("ar_post_imm", 64'(out_imm), 64'h12345000);
    in_valid = 1'b0;
    step();
    check("ar_post_drained", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
